// File: rtl/wb_init_pkg.sv
// Shared widths and FSM encoding for the Wishbone initiator.
package wb_init_pkg;

    localparam int WB_DW   = 32;
    localparam int WB_AW   = 32;
    localparam int WB_SELW = 4;
    localparam int LEN_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WDAT = 2'd1,
        REQ  = 2'd2,
        RSP  = 2'd3
    } state_e;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Per-beat watchdog: counts cycles while enabled, flags the last allowed cycle.
module wb_timeout_cnt #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    // Expired on the TIMEOUT-th enabled cycle, so the beat sees exactly TIMEOUT strobe cycles.
    assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

    // Next count: restart on clear, saturate once expired.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (en_i && !expired_o)
            cnt_d = cnt_q + CW'(1);
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic initiator: command port -> single/burst bus cycles,
// one response per beat, per-beat ack timeout.
module wb_initiator
    import wb_init_pkg::*;
#(
    parameter int TIMEOUT   = 64,
    parameter int ADDR_STEP = 4
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_we,
    input  logic [WB_AW-1:0]   cmd_adr,
    input  logic [WB_SELW-1:0] cmd_sel,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic               wd_valid,
    output logic               wd_ready,
    input  logic [WB_DW-1:0]   wd_data,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [WB_SELW-1:0] wbm_sel_o,
    output logic [WB_AW-1:0]   wbm_adr_o,
    output logic [WB_DW-1:0]   wbm_dat_o,
    input  logic               wbm_ack_i,
    input  logic [WB_DW-1:0]   wbm_dat_i,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WB_DW-1:0]   rsp_dat,
    output logic               rsp_err,
    output logic               rsp_last
);

    state_e             state_q;
    logic [LEN_W-1:0]   beats_q;
    logic               tmo_expired;

    assign cmd_ready = (state_q == IDLE);

    // Counter runs only while a strobe is outstanding; any other state rearms it.
    wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk_i     (wb_clk_i),
        .rst_ni    (wb_rst_ni),
        .clear_i   (state_q != REQ),
        .en_i      (state_q == REQ),
        .expired_o (tmo_expired)
    );

    // Command FSM with all bus and response outputs registered.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            beats_q   <= '0;
            wd_ready  <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            rsp_last  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        wbm_we_o  <= cmd_we;
                        wbm_adr_o <= cmd_adr;
                        wbm_sel_o <= cmd_sel;
                        beats_q   <= cmd_len;
                        wbm_cyc_o <= 1'b1;
                        if (cmd_we) begin
                            wd_ready <= 1'b1;
                            state_q  <= WDAT;
                        end else begin
                            wbm_stb_o <= 1'b1;
                            state_q   <= REQ;
                        end
                    end
                end
                WDAT: begin
                    if (wd_valid) begin
                        wbm_dat_o <= wd_data;
                        wd_ready  <= 1'b0;
                        wbm_stb_o <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    // Ack takes priority over a simultaneous timeout.
                    if (wbm_ack_i) begin
                        rsp_valid <= 1'b1;
                        rsp_dat   <= wbm_we_o ? '0 : wbm_dat_i;
                        rsp_err   <= 1'b0;
                        rsp_last  <= (beats_q == '0);
                        wbm_stb_o <= 1'b0;
                        state_q   <= RSP;
                    end else if (tmo_expired) begin
                        // Abort the whole command; remaining beats are dropped.
                        rsp_valid <= 1'b1;
                        rsp_dat   <= '0;
                        rsp_err   <= 1'b1;
                        rsp_last  <= 1'b1;
                        wbm_stb_o <= 1'b0;
                        wbm_cyc_o <= 1'b0;
                        state_q   <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_last) begin
                            wbm_cyc_o <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            beats_q   <= beats_q - LEN_W'(1);
                            wbm_adr_o <= wbm_adr_o + WB_AW'(ADDR_STEP);
                            if (wbm_we_o) begin
                                wd_ready <= 1'b1;
                                state_q  <= WDAT;
                            end else begin
                                wbm_stb_o <= 1'b1;
                                state_q   <= REQ;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator: table of single beats plus hand sequences
// for bursts, timeout, back-pressure, stray acks, reset and address wrap.
module tb_wb_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr;
    logic [3:0]  cmd_sel, cmd_len;
    logic        wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_last;
    logic [31:0] rsp_dat;

    // Responder model knobs.
    logic        ack_en = 1'b1;
    logic        stray_ack = 1'b0;
    int          ack_n = 1;
    int          stb_cnt = 0;
    int          stb_run = 0;

    typedef struct {logic [31:0] adr; logic [31:0] dat; logic we; logic [3:0] sel;} beat_t;
    typedef struct {logic [31:0] dat; logic err; logic last;} rsp_t;
    beat_t       beat_q[$];
    rsp_t        rsp_q[$];
    int          stb_runs[$];
    logic [31:0] wd_q[$];

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic [31:0] rdat;
        int          ack_n;
        logic [31:0] exp_dat;
        int          exp_stb;
    } vec_t;
    vec_t vecs[4];

    int checks = 0;
    int errors = 0;

    wb_initiator #(.TIMEOUT(64), .ADDR_STEP(4)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_sel   (cmd_sel),
        .cmd_len   (cmd_len),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_dat_i (wbm_dat_i),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .rsp_last  (rsp_last)
    );

    always #5 clk = ~clk;

    // Responder acks on the ack_n-th strobe cycle of each beat.
    assign wbm_ack_i = (ack_en && wbm_cyc_o && wbm_stb_o && (stb_cnt == ack_n - 1)) || stray_ack;

    always @(posedge clk) begin
        if (wbm_stb_o && !wbm_ack_i) stb_cnt <= stb_cnt + 1;
        else                         stb_cnt <= 0;
        if (wbm_stb_o) stb_run <= stb_run + 1;
        else if (stb_run != 0) begin
            stb_runs.push_back(stb_run);
            stb_run <= 0;
        end
        if (wbm_cyc_o && wbm_stb_o && wbm_ack_i)
            beat_q.push_back('{wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o});
        if (rsp_valid && rsp_ready)
            rsp_q.push_back('{rsp_dat, rsp_err, rsp_last});
        if (wd_valid && wd_ready)
            void'(wd_q.pop_front());
    end

    // Write-data source presents the head of wd_q.
    always @(negedge clk) begin
        if (wd_q.size() > 0) begin
            wd_valid = 1'b1;
            wd_data  = wd_q[0];
        end else begin
            wd_valid = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic clear_logs();
        beat_q.delete();
        rsp_q.delete();
        stb_runs.delete();
    endtask

    task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                            input logic [3:0] len);
        @(negedge clk);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_len = len;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Issue a command and run until the last response has been handshaken.
    task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [3:0] len, output int cyc_low);
        int  n;
        bit  done;
        send_cmd(we, adr, sel, len);
        cyc_low = 0; done = 0; n = 0;
        while (!done && n < 500) begin
            if (rsp_valid && rsp_ready && rsp_last) done = 1;
            else begin
                if (!wbm_cyc_o) cyc_low++;
                @(negedge clk);
                n++;
            end
        end
        chk("run_cmd_finished", 32'(done), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_rsp_count(input int cnt);
        int n = 0;
        while (rsp_q.size() < cnt && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_count_wait", 32'(rsp_q.size() >= cnt), 32'd1);
    endtask

    initial begin
        int cl, bad, n;

        vecs[0] = '{1'b0, 32'h3800_0000, 4'hF, 32'h0,         32'hDEAD_BEEF, 12, 32'hDEAD_BEEF, 12};
        vecs[1] = '{1'b0, 32'h1000_0004, 4'h3, 32'h0,         32'h1234_5678, 1,  32'h1234_5678, 1};
        vecs[2] = '{1'b1, 32'h2000_0008, 4'hC, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 3,  32'h0,         3};
        vecs[3] = '{1'b1, 32'h0000_0000, 4'h1, 32'h0000_00FF, 32'h0BAD_F00D, 1,  32'h0,         1};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_sel = '0; cmd_len = '0;
        wd_valid = 1'b0; wd_data = '0; rsp_ready = 1'b1; wbm_dat_i = '0;

        // Reset state.
        #3;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_wd_ready", 32'(wd_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table of single-beat commands.
        for (int i = 0; i < 4; i++) begin
            clear_logs();
            ack_n = vecs[i].ack_n;
            wbm_dat_i = vecs[i].rdat;
            if (vecs[i].we) wd_q.push_back(vecs[i].wdat);
            run_cmd(vecs[i].we, vecs[i].adr, vecs[i].sel, 4'd0, cl);
            chk($sformatf("v%0d_rsp_cnt", i), 32'(rsp_q.size()), 32'd1);
            chk($sformatf("v%0d_beat_cnt", i), 32'(beat_q.size()), 32'd1);
            if (rsp_q.size() > 0) begin
                chk($sformatf("v%0d_rsp_dat", i), rsp_q[0].dat, vecs[i].exp_dat);
                chk($sformatf("v%0d_rsp_err", i), 32'(rsp_q[0].err), 32'd0);
                chk($sformatf("v%0d_rsp_last", i), 32'(rsp_q[0].last), 32'd1);
            end
            if (beat_q.size() > 0) begin
                chk($sformatf("v%0d_adr", i), beat_q[0].adr, vecs[i].adr);
                chk($sformatf("v%0d_we", i), 32'(beat_q[0].we), 32'(vecs[i].we));
                chk($sformatf("v%0d_sel", i), 32'(beat_q[0].sel), 32'(vecs[i].sel));
                if (vecs[i].we) chk($sformatf("v%0d_wdat", i), beat_q[0].dat, vecs[i].wdat);
            end
            chk($sformatf("v%0d_stb_len", i), 32'(stb_runs.size() > 0 ? stb_runs[0] : -1),
                32'(vecs[i].exp_stb));
            chk($sformatf("v%0d_cmd_ready_after", i), 32'(cmd_ready), 32'd1);
        end

        // Write burst of four beats.
        clear_logs();
        ack_n = 2;
        wbm_dat_i = 32'hCAFE_0000;
        for (int i = 1; i <= 4; i++) wd_q.push_back(32'(i));
        run_cmd(1'b1, 32'h3800_0010, 4'hF, 4'd3, cl);
        chk("wb_cyc_gaps", 32'(cl), 32'd0);
        chk("wb_beat_cnt", 32'(beat_q.size()), 32'd4);
        chk("wb_rsp_cnt", 32'(rsp_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < beat_q.size()) begin
                chk($sformatf("wb_adr%0d", i), beat_q[i].adr, 32'h3800_0010 + 32'(4 * i));
                chk($sformatf("wb_dat%0d", i), beat_q[i].dat, 32'(i + 1));
            end
            if (i < rsp_q.size()) begin
                chk($sformatf("wb_last%0d", i), 32'(rsp_q[i].last), 32'(i == 3));
                chk($sformatf("wb_rdat%0d", i), rsp_q[i].dat, 32'h0);
            end
        end

        // Timeout on a read burst that is never acked.
        clear_logs();
        ack_en = 1'b0;
        send_cmd(1'b0, 32'h0000_0100, 4'hF, 4'd7);
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("to_rsp_seen", 32'(rsp_valid), 32'd1);
        chk("to_cyc_drop", 32'(wbm_cyc_o), 32'd0);
        chk("to_stb_drop", 32'(wbm_stb_o), 32'd0);
        chk("to_err", 32'(rsp_err), 32'd1);
        chk("to_last", 32'(rsp_last), 32'd1);
        chk("to_dat", rsp_dat, 32'd0);
        repeat (6) @(negedge clk);
        chk("to_stb_len", 32'(stb_runs.size() > 0 ? stb_runs[0] : -1), 32'd64);
        chk("to_rsp_cnt", 32'(rsp_q.size()), 32'd1);
        chk("to_idle", 32'(cmd_ready), 32'd1);
        ack_en = 1'b1;

        // Back-pressure between two read beats.
        clear_logs();
        ack_n = 1;
        wbm_dat_i = 32'h1111_2222;
        rsp_ready = 1'b0;
        send_cmd(1'b0, 32'h0000_0040, 4'hF, 4'd1);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_first_rsp", 32'(rsp_valid), 32'd1);
        chk("bp_first_last", 32'(rsp_last), 32'd0);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (wbm_stb_o !== 1'b0 || wbm_cyc_o !== 1'b1 || rsp_valid !== 1'b1) bad++;
        end
        chk("bp_stall_bus", 32'(bad), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_restart_stb", 32'(wbm_stb_o), 32'd1);
        chk("bp_restart_adr", wbm_adr_o, 32'h0000_0044);
        wait_rsp_count(2);
        if (rsp_q.size() >= 2) begin
            chk("bp_last2", 32'(rsp_q[1].last), 32'd1);
            chk("bp_dat2", rsp_q[1].dat, 32'h1111_2222);
        end
        @(negedge clk);

        // Stray ack in IDLE and in WDAT.
        clear_logs();
        bad = 0;
        stray_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) bad++;
        end
        stray_ack = 1'b0;
        chk("stray_idle", 32'(bad), 32'd0);
        send_cmd(1'b1, 32'h0000_0080, 4'hF, 4'd0);
        chk("stray_wdat_state", 32'(wd_ready), 32'd1);
        bad = 0;
        stray_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) bad++;
        end
        stray_ack = 1'b0;
        chk("stray_wdat", 32'(bad), 32'd0);
        chk("stray_rsp_none", 32'(rsp_q.size()), 32'd0);
        wd_q.push_back(32'h0000_0077);
        wait_rsp_count(1);
        chk("stray_after_cnt", 32'(beat_q.size()), 32'd1);
        if (beat_q.size() > 0) chk("stray_after_dat", beat_q[0].dat, 32'h0000_0077);
        @(negedge clk);

        // Reset asserted while a beat is outstanding.
        ack_en = 1'b0;
        send_cmd(1'b0, 32'h0000_0200, 4'hF, 4'd0);
        repeat (4) @(negedge clk);
        chk("rst_mid_pre_stb", 32'(wbm_stb_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_mid_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_mid_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        ack_en = 1'b1;
        @(negedge clk);

        // Address wrap across 2^32.
        clear_logs();
        ack_n = 1;
        run_cmd(1'b0, 32'hFFFF_FFFC, 4'hF, 4'd1, cl);
        chk("wrap_beat_cnt", 32'(beat_q.size()), 32'd2);
        if (beat_q.size() >= 2) begin
            chk("wrap_adr0", beat_q[0].adr, 32'hFFFF_FFFC);
            chk("wrap_adr1", beat_q[1].adr, 32'h0000_0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
- Wishbone bus initiator: turns single or burst read/write commands from a valid/ready command port into classic Wishbone cycles.
- Returns one response per beat; a write-data stream supplies write beats.
- Sits between firmware-side or LA-side control logic and user Wishbone responders such as the BRAM slave with its multi-cycle ack.
- A per-beat timeout guards against responders that never ack.

Parameters:
- TIMEOUT, 64: cycles in REQ without wbm_ack_i before a beat aborts with error; legal range 2..1023.
- ADDR_STEP, 4: byte increment of wbm_adr_o between burst beats.

Ports:
- wb_clk_i  input  1  single clock, rising edge.
- wb_rst_ni  input  1  asynchronous reset, active-low.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  high only in IDLE.
- cmd_we  input  1  1 = write, 0 = read.
- cmd_adr  input  32  start byte address.
- cmd_sel  input  4  byte select, applied to every beat.
- cmd_len  input  4  beats minus one (1..16 beats).
- wd_valid  input  1  write-data beat offered.
- wd_ready  output  1  write-data beat accepted.
- wd_data  input  32  write-data beat.
- wbm_cyc_o  output  1  Wishbone cycle.
- wbm_stb_o  output  1  Wishbone strobe.
- wbm_we_o  output  1  write enable.
- wbm_sel_o  output  4  byte select.
- wbm_adr_o  output  32  address.
- wbm_dat_o  output  32  write data.
- wbm_ack_i  input  1  responder acknowledge.
- wbm_dat_i  input  32  read data.
- rsp_valid  output  1  response beat available.
- rsp_ready  input  1  response consumed.
- rsp_dat  output  32  read data; 0 for writes.
- rsp_err  output  1  beat timed out.
- rsp_last  output  1  final response of the command.

Behaviour:
- Reset, asynchronous on wb_rst_ni low:
  - state = IDLE.
  - All wbm_* outputs, rsp_* outputs and wd_ready = 0.
  - cmd_ready = 1, since it is combinational from state == IDLE.
  - Internal beat counter and timeout counter = 0.
  - Reset mid-cycle drops cyc/stb immediately; the pending beat is lost.
- States: IDLE, WDAT, REQ, RSP. All wbm_* and rsp_* outputs are registered.
- IDLE:
  - On cmd_valid & cmd_ready, latch we/adr/sel/len and set beats_left = cmd_len.
  - Next state is WDAT if cmd_we, else REQ.
  - wbm_cyc_o rises on entry to WDAT or REQ and stays high until the command ends.
- WDAT:
  - wd_ready = 1.
  - On wd_valid, capture wd_data into wbm_dat_o and go to REQ.
  - No timeout in WDAT.
- REQ:
  - wbm_stb_o = 1, and cyc/we/sel/adr/dat are held stable.
  - The timeout counter increments each cycle.
  - On wbm_ack_i: capture wbm_dat_i into rsp_dat (0 if write), rsp_err = 0, rsp_last = (beats_left == 0), rsp_valid = 1, stb drops next cycle, go to RSP.
  - If the counter reaches TIMEOUT - 1 without ack: rsp_err = 1, rsp_last = 1, rsp_dat = 0, rsp_valid = 1, cyc and stb drop together, remaining beats are cancelled, go to RSP.
  - Ack and timeout on the same cycle: ack wins.
- RSP:
  - wbm_stb_o = 0, giving at least one idle stb cycle between beats.
  - Hold rsp_* until rsp_ready.
  - On handshake with rsp_last: clear cyc and go to IDLE.
  - On handshake otherwise: decrement beats_left, add ADDR_STEP to wbm_adr_o (wraps modulo 2^32), clear the timeout counter, then go to WDAT (write) or REQ (read).
- Ack handling: wbm_ack_i outside REQ is ignored, so it never generates a response.
- Latency, zero-wait responder: command accept to stb = 1 cycle for a read; ack to rsp_valid = 1 cycle.
- Back-pressure: rsp_ready low stalls the bus with cyc held high and stb low.

Decomposition:
- Package wb_init_pkg:
  - state encoding IDLE/WDAT/REQ/RSP.
  - WB_DW = 32, WB_AW = 32, WB_SELW = 4, LEN_W = 4.
- Sub-module wb_timeout_cnt:
  - inputs: clear, enable.
  - output: expired, at TIMEOUT - 1.
  - width = $clog2(TIMEOUT).

Test Plan:
- Single read at 0x3800_0000; responder acks 12 cycles after stb with data 0xDEAD_BEEF.
  - Expect stb high for 12 cycles.
  - Expect rsp_dat = 0xDEAD_BEEF, rsp_err = 0, rsp_last = 1.
  - Expect cmd_ready high again after the rsp handshake.
- Write burst, cmd_len = 3, adr 0x3800_0010, wd beats 1, 2, 3, 4.
  - Expect wbm_adr_o sequence 0x10, 0x14, 0x18, 0x1C with matching wbm_dat_o.
  - Expect 4 responses, rsp_last only on the 4th.
  - Expect cyc continuously high across the burst.
- Timeout: read with no ack and TIMEOUT = 64.
  - Expect stb high exactly 64 cycles, then cyc = stb = 0.
  - Expect rsp_err = 1, rsp_last = 1.
  - Expect cmd_len = 7 to yield only that one response.
- Back-pressure: read burst of 2 with rsp_ready low for 10 cycles after the first ack.
  - Expect stb = 0 and cyc = 1 throughout the stall.
  - Expect the second beat to start 1 cycle after rsp_ready rises.
- Stray ack and reset:
  - wbm_ack_i pulsed in IDLE or WDAT → no rsp_valid.
  - wb_rst_ni low mid-REQ → cyc/stb/rsp_valid = 0 within the same cycle, cmd_ready = 1.
- Address wrap: single-beat-step burst from 0xFFFF_FFFC, cmd_len = 1 → second beat at 0x0000_0000.
